// File: rtl/gpio_cmd_pkg.sv
// Shared constants for the GPIO command register file: command codes,
// FSM state encoding and status-word bit offsets.
package gpio_cmd_pkg;

    localparam int unsigned CMD_KERNEL_SEL     = 0;
    localparam int unsigned CMD_LOAD_FRAME     = 1;
    localparam int unsigned CMD_END_FRAME      = 2;
    localparam int unsigned CMD_IS_FRAME_READY = 3;
    localparam int unsigned CMD_GET_FRAME      = 4;
    localparam int unsigned CMD_GET_STATUS     = 5;
    localparam int unsigned CMD_CLEAR_ERR      = 6;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EXEC     = 2'd1;
    localparam logic [1:0] ST_WAIT_MEM = 2'd2;

    // Status offsets count upward from the bit just above the wr_cnt field
    localparam int unsigned STAT_RDY_OFS     = 0;
    localparam int unsigned STAT_ERR_CMD_OFS = 1;
    localparam int unsigned STAT_ERR_OVF_OFS = 2;
    localparam int unsigned STAT_ERR_LEN_OFS = 3;
    localparam int unsigned STAT_ERR_TMO_OFS = 4;
    localparam int unsigned STAT_BUSY_OFS    = 5;

endpackage

// File: rtl/cmd_edge_detect.sv
// Rising-edge detector for the command ENABLE bit: a 0 then 1 seen on two
// consecutive clock edges gives a one-cycle o_rise pulse.
module cmd_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);

    logic level_p0;
    logic level_p1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            level_p0 <= 1'b0;
            level_p1 <= 1'b0;
        end else begin
            level_p0 <= i_level;
            level_p1 <= level_p0;
        end
    end

    assign o_rise = level_p0 & ~level_p1;

endmodule

// File: rtl/gpio_cmd_regfile.sv
// Command register file between a micro's GPIO word and the frame engine.
// Define FILE_REG_TIMEOUT_EN to bound the memory readback wait.
module gpio_cmd_regfile
    import gpio_cmd_pkg::*;
#(
    parameter int NB_INST     = 32,
    parameter int NB_CMD      = 8,
    parameter int NB_KSEL     = 2,
    parameter int N_KERNELS   = 4,
    parameter int FRAME_WORDS = 16,
    parameter int TIMEOUT_CYC = 64,
    parameter int NB_DATA     = NB_INST - NB_CMD - 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NB_INST-1:0]             i_cmd_from_micro,
    input  logic                           i_frame_ready,
    input  logic [NB_INST-1:0]             i_frame_from_mem,
    input  logic                           i_rd_valid,
    output logic [NB_INST-1:0]             o_data_to_micro,
    output logic [NB_DATA-1:0]             o_frame_from_micro,
    output logic                           o_load,
    output logic                           o_start_conv,
    output logic [NB_KSEL-1:0]             o_kernel_sel,
    output logic                           o_rd_req,
    output logic [$clog2(FRAME_WORDS)-1:0] o_rd_addr
);

    localparam int NB_ADDR = $clog2(FRAME_WORDS);
    localparam int NB_WCNT = $clog2(FRAME_WORDS + 1);
    localparam int POS_RDY     = NB_WCNT + STAT_RDY_OFS;
    localparam int POS_ERR_CMD = NB_WCNT + STAT_ERR_CMD_OFS;
    localparam int POS_ERR_OVF = NB_WCNT + STAT_ERR_OVF_OFS;
    localparam int POS_ERR_LEN = NB_WCNT + STAT_ERR_LEN_OFS;
    localparam int POS_ERR_TMO = NB_WCNT + STAT_ERR_TMO_OFS;
    localparam int POS_BUSY    = NB_WCNT + STAT_BUSY_OFS;

    logic               en_rise;
    logic [NB_CMD-1:0]  op_p0;
    logic [NB_DATA-1:0] data_p0;
    logic [NB_CMD-1:0]  op_p1;
    logic [NB_DATA-1:0] data_p1;
    logic [1:0]         state;
    logic [NB_WCNT-1:0] wr_cnt;
    logic [NB_ADDR-1:0] rd_cnt;
    logic               err_cmd;
    logic               err_ovf;
    logic               err_len;
    logic               err_tmo;
    logic [NB_INST-1:0] status;
    logic               ksel_ok;
    logic               frame_full;
`ifdef FILE_REG_TIMEOUT_EN
    localparam int NB_TMO = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [NB_TMO-1:0]  tmo_cnt;
`endif

    cmd_edge_detect u_edge (
        .clock   (clock),
        .reset   (reset),
        .i_level (i_cmd_from_micro[NB_DATA]),
        .o_rise  (en_rise)
    );

    // Stage p0: command word captured on the same edge as the ENABLE sample
    always_ff @(posedge clock) begin
        op_p0   <= i_cmd_from_micro[NB_INST-1 -: NB_CMD];
        data_p0 <= i_cmd_from_micro[NB_DATA-1:0];
    end

    assign ksel_ok    = {1'b0, data_p1[NB_KSEL-1:0]} < (NB_KSEL + 1)'(N_KERNELS);
    assign frame_full = (wr_cnt == NB_WCNT'(FRAME_WORDS));
    assign o_rd_addr  = rd_cnt;

    // Sampled while in EXEC, so busy always reads back as 1
    always_comb begin
        status              = '0;
        status[NB_WCNT-1:0] = wr_cnt;
        status[POS_RDY]     = i_frame_ready;
        status[POS_ERR_CMD] = err_cmd;
        status[POS_ERR_OVF] = err_ovf;
        status[POS_ERR_LEN] = err_len;
        status[POS_ERR_TMO] = err_tmo;
        status[POS_BUSY]    = (state != ST_IDLE);
    end

    // Stage p1: latched command executes in EXEC, outputs land one edge later
    always_ff @(posedge clock) begin
        if (!reset) begin
            state              <= ST_IDLE;
            op_p1              <= '0;
            data_p1            <= '0;
            wr_cnt             <= '0;
            rd_cnt             <= '0;
            err_cmd            <= 1'b0;
            err_ovf            <= 1'b0;
            err_len            <= 1'b0;
            err_tmo            <= 1'b0;
            o_data_to_micro    <= '0;
            o_frame_from_micro <= '0;
            o_load             <= 1'b0;
            o_start_conv       <= 1'b0;
            o_kernel_sel       <= '0;
            o_rd_req           <= 1'b0;
`ifdef FILE_REG_TIMEOUT_EN
            tmo_cnt            <= '0;
`endif
        end else begin
            o_load       <= 1'b0;
            o_start_conv <= 1'b0;
            o_rd_req     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en_rise) begin
                        op_p1   <= op_p0;
                        data_p1 <= data_p0;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                    case (op_p1)
                        NB_CMD'(CMD_KERNEL_SEL): begin
                            if (ksel_ok) o_kernel_sel <= data_p1[NB_KSEL-1:0];
                            else         err_cmd      <= 1'b1;
                        end
                        NB_CMD'(CMD_LOAD_FRAME): begin
                            if (frame_full) begin
                                err_ovf <= 1'b1;
                            end else begin
                                o_frame_from_micro <= data_p1;
                                o_load             <= 1'b1;
                                wr_cnt             <= wr_cnt + 1'b1;
                            end
                        end
                        NB_CMD'(CMD_END_FRAME): begin
                            if (frame_full) o_start_conv <= 1'b1;
                            else            err_len      <= 1'b1;
                            wr_cnt <= '0;
                        end
                        NB_CMD'(CMD_IS_FRAME_READY): begin
                            o_data_to_micro <= {{(NB_INST-1){1'b0}}, i_frame_ready};
                        end
                        NB_CMD'(CMD_GET_FRAME): begin
                            if (i_frame_ready) begin
                                o_rd_req <= 1'b1;
                                state    <= ST_WAIT_MEM;
`ifdef FILE_REG_TIMEOUT_EN
                                tmo_cnt  <= '0;
`endif
                            end else begin
                                o_data_to_micro <= '0;
                            end
                        end
                        NB_CMD'(CMD_GET_STATUS): o_data_to_micro <= status;
                        NB_CMD'(CMD_CLEAR_ERR): begin
                            err_cmd <= 1'b0;
                            err_ovf <= 1'b0;
                            err_len <= 1'b0;
                            err_tmo <= 1'b0;
                        end
                        default: err_cmd <= 1'b1;
                    endcase
                end
                ST_WAIT_MEM: begin
                    if (i_rd_valid) begin
                        o_data_to_micro <= i_frame_from_mem;
                        rd_cnt          <= (rd_cnt == NB_ADDR'(FRAME_WORDS - 1)) ? '0 : rd_cnt + 1'b1;
                        state           <= ST_IDLE;
                    end
`ifdef FILE_REG_TIMEOUT_EN
                    else if (tmo_cnt == NB_TMO'(TIMEOUT_CYC - 1)) begin
                        o_data_to_micro <= '1;
                        err_tmo         <= 1'b1;
                        state           <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
            // A new edge while busy is dropped but flagged; wins over CLEAR_ERR
            if (en_rise && (state != ST_IDLE)) err_cmd <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gpio_cmd_regfile.sv
// Directed and randomized bench for gpio_cmd_regfile against a command-level
// reference model; honours FILE_REG_TIMEOUT_EN for the readback-wait tests.
module tb_gpio_cmd_regfile;

    localparam int FW = 16;
    localparam logic [7:0] OP_KSEL = 8'd0, OP_LOAD = 8'd1, OP_END = 8'd2, OP_RDY = 8'd3,
                           OP_GET  = 8'd4, OP_STAT = 8'd5, OP_CLR = 8'd6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_cmd_from_micro = '0;
    logic        i_frame_ready = 1'b0;
    logic [31:0] i_frame_from_mem = '0;
    logic        i_rd_valid = 1'b0;
    logic [31:0] o_data_to_micro;
    logic [22:0] o_frame_from_micro;
    logic        o_load;
    logic        o_start_conv;
    logic [1:0]  o_kernel_sel;
    logic        o_rd_req;
    logic [3:0]  o_rd_addr;

    int nchk = 0;
    int nfail = 0;

    int          m_wr, m_rd, m_ksel, m_starts, m_reqs;
    bit          e_cmd, e_ovf, e_len, e_tmo;
    logic [31:0] m_resp;
    logic [22:0] m_loads[$];
    logic [22:0] seen_loads[$];
    int          seen_starts = 0;
    int          seen_reqs = 0;
    logic [1:0]  pre_ksel;
    int          mem_delay = 3;
    logic [31:0] mem_data = '0;

    gpio_cmd_regfile dut (
        .clock              (clock),
        .reset              (reset),
        .i_cmd_from_micro   (i_cmd_from_micro),
        .i_frame_ready      (i_frame_ready),
        .i_frame_from_mem   (i_frame_from_mem),
        .i_rd_valid         (i_rd_valid),
        .o_data_to_micro    (o_data_to_micro),
        .o_frame_from_micro (o_frame_from_micro),
        .o_load             (o_load),
        .o_start_conv       (o_start_conv),
        .o_kernel_sel       (o_kernel_sel),
        .o_rd_req           (o_rd_req),
        .o_rd_addr          (o_rd_addr)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            if (o_load) seen_loads.push_back(o_frame_from_micro);
            if (o_start_conv) seen_starts++;
            if (o_rd_req) seen_reqs++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        return {21'b0, 1'b1, e_tmo, e_len, e_ovf, e_cmd, i_frame_ready, 5'(m_wr)};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        i_cmd_from_micro = '0;
        i_rd_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        m_wr = 0; m_rd = 0; m_ksel = 0; m_resp = '0;
        e_cmd = 0; e_ovf = 0; e_len = 0; e_tmo = 0;
    endtask

    // Raise ENABLE for one sample, return at the first negedge where results are visible
    task automatic send(input logic [7:0] op, input logic [22:0] d);
        i_cmd_from_micro = {op, 1'b1, d};
        @(negedge clock);
        i_cmd_from_micro = {op, 1'b0, d};
        @(negedge clock);
        pre_ksel = o_kernel_sel;
        @(negedge clock);
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [22:0] d);
        send(op, d);
        case (op)
            OP_KSEL: m_ksel = int'(d[1:0]);
            OP_LOAD: begin
                if (m_wr == FW) begin
                    e_ovf = 1;
                    check("load_dropped", o_load, 0);
                end else begin
                    m_loads.push_back(d);
                    m_wr++;
                    check("load_strobe", o_load, 1);
                    check("load_data", o_frame_from_micro, d);
                end
            end
            OP_END: begin
                if (m_wr == FW) begin
                    m_starts++;
                    check("start_pulse", o_start_conv, 1);
                end else begin
                    e_len = 1;
                    check("no_start", o_start_conv, 0);
                end
                m_wr = 0;
            end
            OP_RDY:  m_resp = {31'b0, i_frame_ready};
            OP_STAT: m_resp = status_exp();
            OP_CLR:  begin e_cmd = 0; e_ovf = 0; e_len = 0; e_tmo = 0; end
            OP_GET: begin
                if (!i_frame_ready) begin
                    m_resp = '0;
                    check("no_req", o_rd_req, 0);
                end else begin
                    check("rd_req", o_rd_req, 1);
                    check("rd_addr", o_rd_addr, m_rd);
                    m_reqs++;
                    repeat (mem_delay - 1) @(negedge clock);
                    i_frame_from_mem = mem_data;
                    i_rd_valid = 1'b1;
                    @(negedge clock);
                    i_rd_valid = 1'b0;
                    m_resp = mem_data;
                    m_rd = (m_rd + 1) % FW;
                    check("rd_addr_next", o_rd_addr, m_rd);
                end
            end
            default: e_cmd = 1;
        endcase
        check("resp", o_data_to_micro, m_resp);
        check("ksel", o_kernel_sel, m_ksel);
    endtask

    initial begin
        int n;
        int r;
        logic [7:0] op;

        do_reset();
        check("rst_data", o_data_to_micro, 0);
        check("rst_ksel", o_kernel_sel, 0);
        check("rst_load", o_load, 0);
        check("rst_start", o_start_conv, 0);
        check("rst_rdreq", o_rd_req, 0);
        check("rst_rdaddr", o_rd_addr, 0);
        check("rst_frame", o_frame_from_micro, 0);

        do_cmd(OP_KSEL, 23'd3);
        check("ksel_latency", pre_ksel, 0);
        do_cmd(OP_KSEL, 23'd2);

        for (int i = 0; i < FW; i++) do_cmd(OP_LOAD, 23'(i));
        do_cmd(OP_LOAD, 23'h7ABCDE);
        do_cmd(OP_END, 23'd0);
        do_cmd(OP_STAT, 23'd0);
        check("wr_cnt_cleared", o_data_to_micro[4:0], 0);
        check("err_ovf_set", o_data_to_micro[7], 1);

        for (int i = 0; i < 3; i++) do_cmd(OP_LOAD, 23'(100 + i));
        do_cmd(OP_END, 23'd0);
        do_cmd(OP_STAT, 23'd0);
        check("err_len_set", o_data_to_micro[8], 1);
        do_cmd(OP_CLR, 23'd0);
        do_cmd(OP_STAT, 23'd0);
        check("errs_cleared", o_data_to_micro[9:6], 0);
        do_cmd(8'd99, 23'd0);

        i_frame_from_mem = 32'h1234_5678;
        i_rd_valid = 1'b1;
        @(negedge clock);
        i_rd_valid = 1'b0;
        @(negedge clock);
        check("stray_rd_valid", o_data_to_micro, m_resp);

        i_frame_ready = 1'b0;
        do_cmd(OP_GET, 23'd0);
        i_frame_ready = 1'b1;
        do_cmd(OP_RDY, 23'd0);
        mem_delay = 3;
        mem_data = 32'hA5A5_A5A5;
        do_cmd(OP_GET, 23'd0);
        check("mem_word", o_data_to_micro, 32'hA5A5_A5A5);
        for (int i = 1; i <= 16; i++) begin
            mem_data = $urandom & 32'h7FFF_FFFF;
            do_cmd(OP_GET, 23'd0);
            if (i == 15) check("rd_addr_wrap", o_rd_addr, 0);
        end

        i_frame_ready = 1'b1;
        send(OP_GET, 23'd0);
        check("wait_rd_req", o_rd_req, 1);
        m_reqs++;
        send(OP_KSEL, 23'd1);
        e_cmd = 1;
        n = 3;
        check("busy_cmd_ignored", o_kernel_sel, m_ksel);
`ifdef FILE_REG_TIMEOUT_EN
        while (o_data_to_micro !== 32'hFFFF_FFFF && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("tmo_latency", n, 64);
        m_resp = 32'hFFFF_FFFF;
        e_tmo = 1;
        check("tmo_resp", o_data_to_micro, m_resp);
        check("tmo_rd_addr", o_rd_addr, m_rd);
`else
        repeat (80) @(negedge clock);
        check("wait_holds", o_data_to_micro, m_resp);
        mem_data = 32'h0BAD_F00D;
        i_frame_from_mem = mem_data;
        i_rd_valid = 1'b1;
        @(negedge clock);
        i_rd_valid = 1'b0;
        m_resp = mem_data;
        m_rd = (m_rd + 1) % FW;
        check("late_resp", o_data_to_micro, m_resp);
`endif
        do_cmd(OP_STAT, 23'd0);
        check("err_cmd_busy", o_data_to_micro[6], 1);

        for (int i = 0; i < 90; i++) begin
            r = $urandom_range(0, 11);
            if (r == 11)     op = 8'($urandom_range(7, 255));
            else if (r >= 7) op = OP_LOAD;
            else             op = 8'(r);
            i_frame_ready = 1'($urandom_range(0, 1));
            mem_delay = $urandom_range(1, 5);
            mem_data = $urandom;
            do_cmd(op, 23'($urandom));
        end

        i_frame_ready = 1'b1;
        send(OP_GET, 23'd0);
        m_reqs++;
        @(negedge clock);
        do_reset();
        i_frame_from_mem = 32'hDEAD_BEEF;
        i_rd_valid = 1'b1;
        @(negedge clock);
        i_rd_valid = 1'b0;
        @(negedge clock);
        check("reset_abort_data", o_data_to_micro, 0);
        check("reset_abort_addr", o_rd_addr, 0);
        do_cmd(OP_STAT, 23'd0);

        #1;
        check("load_count", seen_loads.size(), m_loads.size());
        for (int i = 0; i < m_loads.size() && i < seen_loads.size(); i++)
            check("load_word", seen_loads[i], m_loads[i]);
        check("start_count", seen_starts, m_starts);
        check("req_count", seen_reqs, m_reqs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
